aes_key_expansion: RTL and testbench

AES_KEY_EXPANSION -- requirements
Module: aes_key_expansion

---
 rtl/aes_pkg.sv | 28 ++
 rtl/aes_key_expansion_if.sv | 18 +
 rtl/aes_key_expansion_sub_word.sv | 9 +
 rtl/aes_key_expansion.sv | 58 +++++
 tb/tb_aes_key_expansion.sv | 113 +++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants (S-box, round constants) and key-expansion FSM states
package aes_pkg;
  localparam logic [3:0] NUM_ROUNDS = 4'd10;
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // Index 0 and 11-15 are padding so any 4-bit counter value selects something defined
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };
endpackage

// File: rtl/aes_key_expansion_if.sv
// aes_key_expansion_if: key-load request and round-key read port between encryption core and key expander
interface aes_key_expansion_if;
  logic key_load;
  logic [127:0] key_in;
  logic [3:0] round_key_addr;
  logic [127:0] round_key_output;
  logic [127:0] round_key_0;
  logic keys_ready;
  logic busy;
  modport master (
    output key_load, key_in, round_key_addr,
    input round_key_output, round_key_0, keys_ready, busy
  );
  modport slave (
    input key_load, key_in, round_key_addr,
    output round_key_output, round_key_0, keys_ready, busy
  );
endinterface

// File: rtl/aes_key_expansion_sub_word.sv
// sub_word: combinational AES SubWord, S-box applied to each byte of a 32-bit word
module sub_word
  import aes_pkg::*;
(
  input logic [31:0] word_in,
  output logic [31:0] word_out
);
  assign word_out = {SBOX[word_in[31:24]], SBOX[word_in[23:16]], SBOX[word_in[15:8]], SBOX[word_in[7:0]]};
endmodule

// File: rtl/aes_key_expansion.sv
// aes_key_expansion: iterative AES-128 key schedule, one round key per clock into an 11-entry store.
// Build option KEY_OUTPUT_GATE_EN zeroes both key outputs while keys_ready is low.
module aes_key_expansion
  import aes_pkg::*;
(
  input logic clk,
  input logic n_rst,
  aes_key_expansion_if.slave kif
);
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [127:0] rk [0:10];
  logic [127:0] prev, sel;
  logic [31:0] sw, w4, w5, w6, w7;
  logic ready, bsy;
  assign prev = rk[cnt - 4'd1];
  sub_word u_sub_word (.word_in({prev[23:0], prev[31:24]}), .word_out(sw));
  assign w4 = prev[127:96] ^ sw ^ {RCON[cnt], 24'h0};
  assign w5 = prev[95:64] ^ w4;
  assign w6 = prev[63:32] ^ w5;
  assign w7 = prev[31:0] ^ w6;
  // State register
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= state_nxt;
  // Next state: a load always restarts; expansion finishes on the edge writing the last key
  always_comb
    state_nxt = kif.key_load ? EXPAND
              : (state == EXPAND && cnt == NUM_ROUNDS) ? READY
              : state;
  // Status outputs decode directly from the state register
  always_comb begin
    ready = state == READY;
    bsy = state == EXPAND;
  end
  // Key store and round counter: capture on load, derive one round key per edge while expanding
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      cnt <= '0;
      for (int i = 0; i <= 10; i++) rk[i] <= '0;
    end else if (kif.key_load) begin
      rk[0] <= kif.key_in;
      cnt <= 4'd1;
    end else if (state == EXPAND) begin
      rk[cnt] <= {w4, w5, w6, w7};
      cnt <= cnt + 4'd1;
    end
  assign sel = (kif.round_key_addr <= NUM_ROUNDS) ? rk[kif.round_key_addr] : '0;
  assign kif.keys_ready = ready;
  assign kif.busy = bsy;
`ifdef KEY_OUTPUT_GATE_EN
  assign kif.round_key_output = ready ? sel : '0;
  assign kif.round_key_0 = ready ? rk[0] : '0;
`else
  assign kif.round_key_output = sel;
  assign kif.round_key_0 = rk[0];
`endif
endmodule

// File: tb/tb_aes_key_expansion.sv
// tb_aes_key_expansion: directed FIPS-197 vectors, abort/reload, reset and address-boundary checks
module tb_aes_key_expansion;
  logic clk = 0;
  logic n_rst;
  int checks = 0;
  int errors = 0;
  localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  aes_key_expansion_if kif ();
  aes_key_expansion dut (.clk(clk), .n_rst(n_rst), .kif(kif));
  always #5 clk = ~clk;
  function automatic logic [127:0] gate(input logic [127:0] v, input logic rdy);
`ifdef KEY_OUTPUT_GATE_EN
    return rdy ? v : '0;
`else
    return v;
`endif
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [127:0] k);
    kif.key_in = k;
    kif.key_load = 1;
    tick(1);
    kif.key_load = 0;
  endtask
  task automatic rd(input string tag, input logic [3:0] a, input logic [127:0] exp);
    kif.round_key_addr = a;
    #1;
    chk(tag, kif.round_key_output, exp);
  endtask
  initial begin
    n_rst = 0;
    kif.key_load = 0;
    kif.key_in = '0;
    kif.round_key_addr = 4'd0;
    tick(2);
    chk("rst_out", kif.round_key_output, '0);
    chk("rst_rk0", kif.round_key_0, '0);
    chk("rst_ready", 128'(kif.keys_ready), 128'd0);
    chk("rst_busy", 128'(kif.busy), 128'd0);
    n_rst = 1;
    tick(1);
    load(FIPS);
    chk("load_busy", 128'(kif.busy), 128'd1);
    chk("load_ready", 128'(kif.keys_ready), 128'd0);
    chk("expand_rk0", kif.round_key_0, gate(FIPS, 0));
    chk("expand_addr0", kif.round_key_output, gate(FIPS, 0));
    tick(9);
    chk("edge10_ready", 128'(kif.keys_ready), 128'd0);
    chk("edge10_busy", 128'(kif.busy), 128'd1);
    tick(1);
    chk("edge11_ready", 128'(kif.keys_ready), 128'd1);
    chk("edge11_busy", 128'(kif.busy), 128'd0);
    chk("fips_rk0", kif.round_key_0, FIPS);
    rd("fips_addr0", 4'd0, FIPS);
    rd("fips_addr1", 4'd1, FIPS1);
    rd("fips_addr2", 4'd2, FIPS2);
    rd("fips_addr10", 4'd10, FIPS10);
    rd("addr11", 4'd11, '0);
    rd("addr15", 4'd15, '0);
    tick(4);
    rd("hold_addr10", 4'd10, FIPS10);
    chk("hold_ready", 128'(kif.keys_ready), 128'd1);
    load('0);
    chk("reload_ready", 128'(kif.keys_ready), 128'd0);
    chk("reload_busy", 128'(kif.busy), 128'd1);
    tick(10);
    chk("zero_ready", 128'(kif.keys_ready), 128'd1);
    rd("zero_addr1", 4'd1, ZERO1);
    rd("zero_addr10", 4'd10, ZERO10);
    load('0);
    tick(3);
    load(FIPS);
    tick(9);
    chk("abort_edge10_ready", 128'(kif.keys_ready), 128'd0);
    tick(1);
    chk("abort_edge11_ready", 128'(kif.keys_ready), 128'd1);
    rd("abort_addr10", 4'd10, FIPS10);
    rd("abort_addr1", 4'd1, FIPS1);
    load(FIPS);
    tick(5);
    chk("pre_rst_busy", 128'(kif.busy), 128'd1);
    #2;
    n_rst = 0;
    #1;
    chk("async_rk0", kif.round_key_0, '0);
    chk("async_out", kif.round_key_output, '0);
    chk("async_busy", 128'(kif.busy), 128'd0);
    chk("async_ready", 128'(kif.keys_ready), 128'd0);
    tick(1);
    n_rst = 1;
    tick(12);
    chk("post_rst_busy", 128'(kif.busy), 128'd0);
    chk("post_rst_ready", 128'(kif.keys_ready), 128'd0);
    chk("post_rst_rk0", kif.round_key_0, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
